rand_buff: RTL and testbench

RAND_BUFF -- requirements
Module: rand_buff

---
 rtl/rand_buff.sv | 166 ++++++++++++++++
 tb/tb_rand_buff.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_buff.sv
// rand_buff: xorshift32 random-word generator feeding a small show-ahead FIFO.
//
// The generator only advances when its word is actually pushed, so the
// consumer sees an unbroken xorshift32 sequence regardless of read gaps.
//
// Parameters:
//   DEPTH  FIFO entries, power of two in 2..16
//   SEED   generator reset state (0 is replaced by 1)
//
// Ports:
//   clk            rising-edge clock
//   rstn           asynchronous active-low reset
//   enable         allows the generator to push into the FIFO
//   seed_load      one-cycle reseed of the generator plus FIFO flush
//   seed_in[31:0]  new generator state, sampled with seed_load
//   rand_rd        consumer pop request
//   rand_ready     at least one word buffered (registered)
//   rand_data      head-of-FIFO word, valid while rand_ready (registered)
//   underflow_cnt  saturating count of reads while empty
//                  (only with RAND_BUFF_STATS_EN defined)
//
// Optional feature macro: RAND_BUFF_STATS_EN
module rand_buff #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        seed_load,
    input  logic [31:0] seed_in,
    input  logic        rand_rd,
    output logic        rand_ready,
    output logic [31:0] rand_data
`ifdef RAND_BUFF_STATS_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int unsigned W     = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

    // One xorshift32 step; every shift truncates to 32 bits.
    function automatic logic [W-1:0] xs32(input logic [W-1:0] x);
        logic [W-1:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    logic [W-1:0]     x_q, x_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic             rand_ready_q, rand_ready_d;
    logic [W-1:0]     rand_data_q, rand_data_d;

    logic [W-1:0]     gen_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;

    // Handshake decode; rand_ready_q always equals (count_q != 0).
    always_comb begin
        gen_c  = xs32(x_q);
        full_c = (count_q == CNT_W'(DEPTH));
        pop_c  = rand_rd && rand_ready_q && !seed_load;
        // A pop in the same cycle frees the slot the push needs.
        push_c = enable && !seed_load && (!full_c || pop_c);
    end

    // Next-state for generator, pointers, count and storage.
    always_comb begin
        x_d      = x_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (seed_load) begin
            x_d      = (seed_in == '0) ? W'(1) : seed_in;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_c) begin
                // When full with a pop, wr_ptr equals rd_ptr: the new word
                // overwrites exactly the slot that is leaving.
                mem_d[wr_ptr_q] = gen_c;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                x_d             = gen_c;
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        // Outputs are registered copies of the next head/occupancy.
        rand_ready_d = (count_d != '0);
        rand_data_d  = mem_d[rd_ptr_d];
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q          <= SEED_EFF;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rand_ready_q <= 1'b0;
            rand_data_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            x_q          <= x_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rand_ready_q <= rand_ready_d;
            rand_data_q  <= rand_data_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rand_ready = rand_ready_q;
    assign rand_data  = rand_data_q;

`ifdef RAND_BUFF_STATS_EN
    logic [15:0] underflow_cnt_q, underflow_cnt_d;

    // Saturating count of reads attempted while empty; cleared by reseed.
    always_comb begin
        underflow_cnt_d = underflow_cnt_q;
        if (seed_load) begin
            underflow_cnt_d = '0;
        end else if (rand_rd && !rand_ready_q && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underflow_cnt_q <= '0;
        end else begin
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign underflow_cnt = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_rand_buff.sv
// tb_rand_buff: directed self-checking bench for rand_buff (DEPTH=4, SEED=1).
module tb_rand_buff;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        seed_load;
    logic [31:0] seed_in;
    logic        rand_rd;
    logic        rand_ready;
    logic [31:0] rand_data;
`ifdef RAND_BUFF_STATS_EN
    logic [15:0] underflow_cnt;
`endif

    int tests_run;
    int tests_failed;

    localparam logic [31:0] FIRST_WORD = 32'h0004_2021;

    rand_buff #(
        .DEPTH(4),
        .SEED (32'h0000_0001)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .rand_rd   (rand_rd),
        .rand_ready(rand_ready),
        .rand_data (rand_data)
`ifdef RAND_BUFF_STATS_EN
        ,
        .underflow_cnt(underflow_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        enable    = 1'b0;
        seed_load = 1'b0;
        seed_in   = 32'h0;
        rand_rd   = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        enable    = 1'b1;
        seed_load = 1'b0;
        seed_in   = 32'h0;
        rand_rd   = 1'b0;
        step();
        step();
        tests_run++;
        if (rand_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 0", rand_ready);
        end
        tests_run++;
        if (rand_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 00000000", rand_data);
        end
        rstn = 1'b1;
        step();
        tests_run++;
        if (rand_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_ready: got %b want 1", rand_ready);
        end
        tests_run++;
        if (rand_data !== FIRST_WORD) begin
            tests_failed++;
            $display("FAIL first_word: got %h want %h", rand_data, FIRST_WORD);
        end
    endtask

    task automatic test_fill();
        logic [31:0] w;
        do_reset();
        enable = 1'b1;
        repeat (10) step();
        tests_run++;
        if (rand_ready !== 1'b1 || rand_data !== FIRST_WORD) begin
            tests_failed++;
            $display("FAIL fill_head: ready %b data %h want 1 %h", rand_ready, rand_data, FIRST_WORD);
        end
        // Drain with the generator stopped: pops still allowed.
        enable  = 1'b0;
        rand_rd = 1'b1;
        w       = 32'h1;
        for (int k = 0; k < 4; k++) begin
            w = xs(w);
            tests_run++;
            if (rand_ready !== 1'b1 || rand_data !== w) begin
                tests_failed++;
                $display("FAIL fill_pop%0d: ready %b data %h want 1 %h", k, rand_ready, rand_data, w);
            end
            step();
        end
        rand_rd = 1'b0;
        tests_run++;
        if (rand_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_empty: got %b want 0", rand_ready);
        end
        // Generator was held while full: next word is iterate 5, no gap.
        enable = 1'b1;
        step();
        w = xs(w);
        tests_run++;
        if (rand_ready !== 1'b1 || rand_data !== w) begin
            tests_failed++;
            $display("FAIL fill_nogap: ready %b data %h want 1 %h", rand_ready, rand_data, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        do_reset();
        enable = 1'b1;
        repeat (6) step();
        rand_rd = 1'b1;
        w       = 32'h1;
        for (int i = 0; i < 20; i++) begin
            w = xs(w);
            tests_run++;
            if (rand_ready !== 1'b1 || rand_data !== w) begin
                tests_failed++;
                $display("FAIL b2b_%0d: ready %b data %h want 1 %h", i, rand_ready, rand_data, w);
            end
            step();
        end
        rand_rd = 1'b0;
        w = xs(w);
        tests_run++;
        if (rand_ready !== 1'b1 || rand_data !== w) begin
            tests_failed++;
            $display("FAIL b2b_tail: ready %b data %h want 1 %h", rand_ready, rand_data, w);
        end
    endtask

    task automatic test_seed_load();
        logic [31:0] w;
        do_reset();
        enable = 1'b1;
        repeat (3) step();
        tests_run++;
        if (rand_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL seed_pre_ready: got %b want 1", rand_ready);
        end
        seed_load = 1'b1;
        seed_in   = 32'h0;
        rand_rd   = 1'b1;
        step();
        seed_load = 1'b0;
        rand_rd   = 1'b0;
        enable    = 1'b0;
        tests_run++;
        if (rand_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL seed_flush: got %b want 0", rand_ready);
        end
        step();
        tests_run++;
        if (rand_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL seed_idle: got %b want 0", rand_ready);
        end
        enable = 1'b1;
        step();
        tests_run++;
        if (rand_ready !== 1'b1 || rand_data !== FIRST_WORD) begin
            tests_failed++;
            $display("FAIL seed_zero_word: ready %b data %h want 1 %h", rand_ready, rand_data, FIRST_WORD);
        end
        // Nonzero reseed with enable held high.
        seed_load = 1'b1;
        seed_in   = 32'hDEAD_BEEF;
        step();
        seed_load = 1'b0;
        tests_run++;
        if (rand_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL seed2_flush: got %b want 0", rand_ready);
        end
        step();
        w = xs(32'hDEAD_BEEF);
        tests_run++;
        if (rand_ready !== 1'b1 || rand_data !== w) begin
            tests_failed++;
            $display("FAIL seed2_word: ready %b data %h want 1 %h", rand_ready, rand_data, w);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        enable  = 1'b0;
        rand_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (rand_ready !== 1'b0 || rand_data !== 32'h0) begin
                tests_failed++;
                $display("FAIL uf_empty%0d: ready %b data %h want 0 00000000", i, rand_ready, rand_data);
            end
        end
        rand_rd = 1'b0;
`ifdef RAND_BUFF_STATS_EN
        tests_run++;
        if (underflow_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL uf_count: got %0d want 3", underflow_cnt);
        end
`endif
        enable = 1'b1;
        step();
        tests_run++;
        if (rand_ready !== 1'b1 || rand_data !== FIRST_WORD) begin
            tests_failed++;
            $display("FAIL uf_nochange: ready %b data %h want 1 %h", rand_ready, rand_data, FIRST_WORD);
        end
`ifdef RAND_BUFF_STATS_EN
        seed_load = 1'b1;
        seed_in   = 32'h1;
        step();
        seed_load = 1'b0;
        tests_run++;
        if (underflow_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL uf_clear: got %0d want 0", underflow_cnt);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        repeat (5) step();
        tests_run++;
        if (rand_ready !== 1'b1 || rand_data === 32'h0) begin
            tests_failed++;
            $display("FAIL ar_full: ready %b data %h want 1 nonzero", rand_ready, rand_data);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (rand_ready !== 1'b0 || rand_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL ar_immediate: ready %b data %h want 0 00000000", rand_ready, rand_data);
        end
        step();
        rstn = 1'b1;
        step();
        tests_run++;
        if (rand_ready !== 1'b1 || rand_data !== FIRST_WORD) begin
            tests_failed++;
            $display("FAIL ar_restart: ready %b data %h want 1 %h", rand_ready, rand_data, FIRST_WORD);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_seed_load();
        test_underflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
